// File: rtl/axis_sigmoid_arbiter_if.sv
// Bundles every stream between the fabric requesters, the arbiter, the sigmoid engine and the result consumers.
// Wiring only: no storage and no latency.
// Backpressure travels on the tready signals of each stream.
interface axis_sigmoid_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    // requester side (port i at [16*i+15:16*i])
    logic [NUM_PORTS*16-1:0] s_axis_tdata;
    logic [NUM_PORTS-1:0]    s_axis_tlast;
    logic [NUM_PORTS-1:0]    s_axis_tvalid;
    logic [NUM_PORTS-1:0]    s_axis_tready;
    // toward the engine
    logic [15:0]             m_eng_tdata;
    logic                    m_eng_tlast;
    logic                    m_eng_tvalid;
    logic                    m_eng_tready;
    // results from the engine
    logic [15:0]             s_eng_tdata;
    logic                    s_eng_tlast;
    logic                    s_eng_tvalid;
    logic                    s_eng_tready;
    // per-port results
    logic [NUM_PORTS*16-1:0] m_axis_tdata;
    logic [NUM_PORTS-1:0]    m_axis_tlast;
    logic [NUM_PORTS-1:0]    m_axis_tvalid;
    logic [NUM_PORTS-1:0]    m_axis_tready;

    // arbiter view
    modport master (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_eng_tdata, m_eng_tlast, m_eng_tvalid,
        input  m_eng_tready,
        input  s_eng_tdata, s_eng_tlast, s_eng_tvalid,
        output s_eng_tready,
        output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    // surrounding fabric / engine view
    modport slave (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_eng_tdata, m_eng_tlast, m_eng_tvalid,
        output m_eng_tready,
        output s_eng_tdata, s_eng_tlast, s_eng_tvalid,
        input  s_eng_tready,
        input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_sigmoid_arbiter.sv
// Packet-granular arbiter sharing one sigmoid engine among NUM_PORTS streams; returned packets are steered back via an order FIFO.
// Latency: grant one cycle after tvalid is seen in IDLE, one idle cycle between packets; return path is zero-cycle combinational.
// Backpressure: engine tready feeds the granted port only; result tready of the head port feeds s_eng_tready; a full order FIFO blocks new grants.
// Define SIGMOID_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module axis_sigmoid_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int ORDER_DEPTH = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    axis_sigmoid_arbiter_if.master  bus
);
    localparam int GW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(ORDER_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        fifo_q [ORDER_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 push, pop, empty, full, any_vld;
    logic [GW-1:0]        winner, head;
    logic [15:0]          eng_dat;
    logic                 eng_last, eng_vld, eng_rdy;
    logic [NUM_PORTS-1:0] in_rdy;
    logic [NUM_PORTS*16-1:0] out_dat;
    logic [NUM_PORTS-1:0] out_last, out_vld;

    assign any_vld = |bus.s_axis_tvalid;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = fifo_q[rd_ptr_q[AW-1:0]];

`ifdef SIGMOID_ARB_FIXED_PRIO_EN
    // lowest-index valid port wins
    always_comb begin
        winner = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.s_axis_tvalid[i]) winner = GW'(i);
        end
    end
`else
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] idx;
    logic          found;

    // round-robin search starting just after the previous grant
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = GW'((int'(last_grant_q) + 1 + i) % NUM_PORTS);
            if (!found && bus.s_axis_tvalid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // last_grant follows every accepted grant
    always_comb begin
        last_grant_d = last_grant_q;
        if (push) last_grant_d = winner;
    end

    // reset value NUM_PORTS-1 gives port 0 first priority
    always_ff @(posedge aclk) begin
        if (!aresetn) last_grant_q <= GW'(NUM_PORTS - 1);
        else          last_grant_q <= last_grant_d;
    end
`endif

    // grant FSM: pick a port in IDLE, stream its packet to the engine in BUSY
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        push     = 1'b0;
        eng_dat  = '0;
        eng_last = 1'b0;
        eng_vld  = 1'b0;
        in_rdy   = '0;
        case (state_q)
            IDLE: begin
                if (any_vld && !full) begin
                    grant_d = winner;
                    push    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_q == GW'(i)) begin
                        eng_dat   = bus.s_axis_tdata[16*i +: 16];
                        eng_last  = bus.s_axis_tlast[i];
                        eng_vld   = bus.s_axis_tvalid[i];
                        in_rdy[i] = bus.m_eng_tready;
                    end
                end
                if (eng_vld && bus.m_eng_tready && eng_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // return path: steer engine results to the port at the order-FIFO head
    always_comb begin
        out_dat  = '0;
        out_last = '0;
        out_vld  = '0;
        eng_rdy  = 1'b0;
        if (!empty) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (head == GW'(i)) begin
                    out_vld[i]          = bus.s_eng_tvalid;
                    out_dat[16*i +: 16] = bus.s_eng_tdata;
                    out_last[i]         = bus.s_eng_tlast;
                    eng_rdy             = bus.m_axis_tready[i];
                end
            end
        end
    end

    assign pop = bus.s_eng_tvalid && eng_rdy && bus.s_eng_tlast;

    assign bus.m_eng_tdata   = eng_dat;
    assign bus.m_eng_tlast   = eng_last;
    assign bus.m_eng_tvalid  = eng_vld;
    assign bus.s_axis_tready = in_rdy;
    assign bus.s_eng_tready  = eng_rdy;
    assign bus.m_axis_tdata  = out_dat;
    assign bus.m_axis_tlast  = out_last;
    assign bus.m_axis_tvalid = out_vld;

    // FSM state, grant and order-FIFO pointers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // order-FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge aclk) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= winner;
    end
endmodule

// File: tb/tb_axis_sigmoid_arbiter.sv
module tb_axis_sigmoid_arbiter;
    localparam int NP = 4;
    localparam int OD = 8;

    typedef logic [16:0] beat_t; // {tlast, tdata}

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_sigmoid_arbiter_if #(.NUM_PORTS(NP)) bus();
    axis_sigmoid_arbiter #(.NUM_PORTS(NP), .ORDER_DEPTH(OD)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    beat_t src_q [NP][$];
    beat_t exp_q [NP][$];
    beat_t got_q [NP][$];
    beat_t eng_q [$];
    int    first_port_log[$];
    int    first_cyc_log[$];
    int    last_cyc_log[$];
    int    exp_order[$];
    int    mcnt[NP];
    int    model_last = NP - 1;
    int    n_assert = 0, n_fail = 0, cyc = 0, seq = 0;
    logic [NP-1:0] out_mask = '1;
    int    out_mode = 0, eng_rnd = 0;
    logic  eng_first = 1'b1;
    logic [NP-1:0] in_hs;
    logic  eng_in_hs = 1'b0, eng_out_hs = 1'b0;
    beat_t eng_in_beat;

    // stand-in for the sigmoid transfer function
    function automatic logic [15:0] eng_f(input logic [15:0] d);
        return ~d ^ 16'h1234;
    endfunction

    // capture handshakes that the next rising edge will complete
    always @(negedge aclk) begin
        cyc++;
        for (int p = 0; p < NP; p++) in_hs[p] = bus.s_axis_tvalid[p] && bus.s_axis_tready[p];
        eng_in_hs = bus.m_eng_tvalid && bus.m_eng_tready;
        if (eng_in_hs) begin
            eng_in_beat = {bus.m_eng_tlast, bus.m_eng_tdata};
            if (eng_first) begin
                first_port_log.push_back(int'(bus.m_eng_tdata[15:12]));
                first_cyc_log.push_back(cyc);
            end
            if (bus.m_eng_tlast) last_cyc_log.push_back(cyc);
            eng_first = bus.m_eng_tlast;
        end
        eng_out_hs = bus.s_eng_tvalid && bus.s_eng_tready;
        for (int p = 0; p < NP; p++)
            if (bus.m_axis_tvalid[p] && bus.m_axis_tready[p])
                got_q[p].push_back({bus.m_axis_tlast[p], bus.m_axis_tdata[16*p +: 16]});
    end

    // sources, engine model and sinks update just after each rising edge
    always @(posedge aclk) begin
        #1;
        for (int p = 0; p < NP; p++) if (in_hs[p]) void'(src_q[p].pop_front());
        if (eng_out_hs) void'(eng_q.pop_front());
        if (eng_in_hs) eng_q.push_back(eng_in_beat);
        in_hs = '0; eng_in_hs = 1'b0; eng_out_hs = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0) begin
                bus.s_axis_tvalid[p]        = 1'b1;
                bus.s_axis_tdata[16*p +: 16] = src_q[p][0][15:0];
                bus.s_axis_tlast[p]         = src_q[p][0][16];
            end else begin
                bus.s_axis_tvalid[p]        = 1'b0;
                bus.s_axis_tdata[16*p +: 16] = 16'h0;
                bus.s_axis_tlast[p]         = 1'b0;
            end
        end
        if (eng_q.size() != 0) begin
            bus.s_eng_tvalid = 1'b1;
            bus.s_eng_tdata  = eng_f(eng_q[0][15:0]);
            bus.s_eng_tlast  = eng_q[0][16];
        end else begin
            bus.s_eng_tvalid = 1'b0;
            bus.s_eng_tdata  = 16'h0;
            bus.s_eng_tlast  = 1'b0;
        end
        bus.m_eng_tready = (eng_q.size() < 64) && (eng_rnd == 0 || $urandom_range(0, 1) == 1);
        for (int p = 0; p < NP; p++)
            bus.m_axis_tready[p] = (out_mode == 0) ? out_mask[p] : ($urandom_range(0, 1) == 1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic push_beat(input int p, input logic [15:0] d, input logic last);
        src_q[p].push_back({last, d});
        exp_q[p].push_back({last, eng_f(d)});
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int k = 0; k < len; k++)
            push_beat(p, {4'(p), 8'(seq), 4'(k)}, k == len - 1);
        seq++;
        mcnt[p]++;
    endtask

    // reference grant order from the arbitration rule over pending packet counts
    task automatic predict(input int npk);
        for (int k = 0; k < npk; k++) begin
            int pick;
            pick = -1;
`ifdef SIGMOID_ARB_FIXED_PRIO_EN
            for (int p = NP - 1; p >= 0; p--) if (mcnt[p] > 0) pick = p;
`else
            for (int s = NP; s >= 1; s--) if (mcnt[(model_last + s) % NP] > 0) pick = (model_last + s) % NP;
`endif
            if (pick >= 0) begin
                exp_order.push_back(pick);
                mcnt[pick]--;
                model_last = pick;
            end
        end
    endtask

    function automatic bit all_done();
        bit d;
        d = (eng_q.size() == 0);
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() != 0 || got_q[p].size() != exp_q[p].size()) d = 0;
        return d;
    endfunction

    task automatic drain(input string tag, input int maxc);
        int c;
        c = 0;
        while (!all_done() && c < maxc) begin
            step();
            c++;
        end
        chk({tag, "_drain_done"}, 64'(all_done()), 64'd1);
    endtask

    task automatic compare_all(input string tag);
        for (int p = 0; p < NP; p++) begin
            int n;
            chk($sformatf("%s_cnt_p%0d", tag, p), 64'(got_q[p].size()), 64'(exp_q[p].size()));
            n = (got_q[p].size() < exp_q[p].size()) ? got_q[p].size() : exp_q[p].size();
            for (int i = 0; i < n; i++)
                chk($sformatf("%s_p%0d_b%0d", tag, p, i), 64'(got_q[p][i]), 64'(exp_q[p][i]));
            got_q[p].delete();
            exp_q[p].delete();
        end
    endtask

    task automatic clear_logs();
        first_port_log.delete();
        first_cyc_log.delete();
        last_cyc_log.delete();
        exp_order.delete();
        for (int p = 0; p < NP; p++) mcnt[p] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot, nl, npk;

        // ---- reset with every port offering packets ----
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) push_pkt(p, 3);
        predict(8);
        repeat (3) step();
        chk("rst_s_axis_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_m_eng_tvalid",  64'(bus.m_eng_tvalid), 64'd0);
        chk("rst_m_eng_tdata",   64'(bus.m_eng_tdata), 64'd0);
        chk("rst_m_axis_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_m_axis_tdata",  64'(bus.m_axis_tdata), 64'd0);
        chk("rst_s_eng_tready",  64'(bus.s_eng_tready), 64'd0);
        aresetn = 1'b1;
        chk("rel_idle_tready", 64'(bus.s_axis_tready), 64'd0);
        step();
        chk("rel_first_grant", 64'(bus.s_axis_tready), 64'(1 << exp_order[0]));

        // ---- round-robin order and one idle cycle between packets ----
        drain("rr", 500);
        chk("rr_npkts", 64'(first_port_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < first_port_log.size(); k++)
            chk($sformatf("rr_order_%0d", k), 64'(first_port_log[k]), 64'(exp_order[k]));
        for (int k = 1; k < 8 && k < first_cyc_log.size(); k++)
            chk($sformatf("rr_gap_%0d", k), 64'(first_cyc_log[k] - last_cyc_log[k-1]), 64'd2);
        compare_all("rr");

        // ---- routing of returned packets ----
        clear_logs();
        push_beat(2, 16'h0000, 1'b0);
        push_beat(2, 16'h0800, 1'b1);
        mcnt[2] = 1; predict(1);
        repeat (3) step();
        push_beat(1, 16'hF800, 1'b1);
        mcnt[1] = 1; predict(1);
        drain("route", 200);
        compare_all("route");

        // ---- order FIFO full: 10 packets, outputs blocked ----
        clear_logs();
        out_mask = '0;
        for (int i = 0; i < 10; i++) push_pkt(i % NP, 1);
        predict(8);
        repeat (40) step();
        chk("full_granted", 64'(first_port_log.size()), 64'd8);
        tot = 0;
        for (int p = 0; p < NP; p++) tot += src_q[p].size();
        chk("full_waiting", 64'(tot), 64'd2);
        for (int k = 0; k < 8 && k < first_port_log.size(); k++)
            chk($sformatf("full_order_%0d", k), 64'(first_port_log[k]), 64'(exp_order[k]));
        out_mask = NP'(1) << exp_order[0];
        step();
        out_mask = '0;
        repeat (20) step();
        chk("full_one_pop", 64'(got_q[exp_order[0]].size()), 64'd1);
        predict(1);
        chk("full_one_grant", 64'(first_port_log.size()), 64'd9);
        if (first_port_log.size() >= 9)
            chk("full_new_port", 64'(first_port_log[8]), 64'(exp_order[8]));
        out_mask = '1;
        predict(1);
        drain("full", 500);
        if (first_port_log.size() >= 10)
            chk("full_last_port", 64'(first_port_log[9]), 64'(exp_order[9]));
        compare_all("full");

        // ---- ports 0 and 3 competing ----
        clear_logs();
        for (int r = 0; r < 3; r++) begin
            push_pkt(0, 2);
            push_pkt(3, 2);
        end
        predict(6);
        drain("prio", 500);
        chk("prio_npkts", 64'(first_port_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < first_port_log.size(); k++)
            chk($sformatf("prio_order_%0d", k), 64'(first_port_log[k]), 64'(exp_order[k]));
        compare_all("prio");

        // ---- random packets under random backpressure ----
        clear_logs();
        out_mode = 1;
        eng_rnd  = 1;
        tot = 0;
        npk = 0;
        while (tot < 200) begin
            int p, len;
            p   = $urandom_range(0, NP - 1);
            len = $urandom_range(1, 4);
            push_pkt(p, len);
            tot += len;
            npk++;
        end
        drain("rand", 8000);
        nl = 0;
        for (int p = 0; p < NP; p++)
            foreach (got_q[p][i]) if (got_q[p][i][16]) nl++;
        chk("rand_tlast_count", 64'(nl), 64'(npk));
        compare_all("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
